// File: rtl/oe_pkg.sv
// Shared types and constants for the output-error stage.
package oe_pkg;

  // Convergence monitor state encodings
  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } mon_state_e;

  // Rounding and error-saturation mode encodings
  localparam logic MODE_TRUNC = 1'b0;
  localparam logic MODE_ROUND = 1'b1;
  localparam logic MODE_WRAP  = 1'b0;
  localparam logic MODE_SAT   = 1'b1;

  // Width of a window sum of squared DW-bit errors
  function automatic int unsigned energy_w(input int unsigned dw, input int unsigned win);
    return 2 * dw + $clog2(win);
  endfunction

endpackage

// File: rtl/oe_conv_mon.sv
// Convergence monitor with hysteresis plus windowed error-energy accumulator.
module oe_conv_mon
  import oe_pkg::*;
#(
  parameter int unsigned DW       = 10,
  parameter int unsigned WIN      = 16,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            xfer,
  input  logic [DW-1:0]                   e,
  input  logic [DW-2:0]                   thresh,
  output logic                            converged,
  output logic [energy_w(DW, WIN)-1:0]    energy,
  output logic                            energy_valid
);

  localparam int unsigned EW   = energy_w(DW, WIN);
  localparam int unsigned SQ_W = 2 * DW;
  localparam int unsigned WW   = $clog2(WIN);
  localparam int unsigned CMAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc_c;
  logic [DW-1:0] e_abs_c;
  logic          in_t_c;
  logic [SQ_W-1:0] sq_c;
  logic [EW-1:0] acc;
  logic [EW-1:0] acc_sum_c;
  logic [WW-1:0] win_cnt;

  // |e| as unsigned; the most negative code maps to 2^(DW-1), above any threshold
  assign e_abs_c   = e[DW-1] ? (~e + DW'(1)) : e;
  assign in_t_c    = (e_abs_c <= DW'(thresh));
  assign cnt_inc_c = cnt + CW'(1);
  assign sq_c      = SQ_W'(e_abs_c) * SQ_W'(e_abs_c);
  assign acc_sum_c = acc + EW'(sq_c);

  // Next-state logic: count consecutive in/out-of-threshold transfers
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (xfer) begin
      if (state == ST_SEARCH) begin
        if (!in_t_c) begin
          cnt_nx = '0;
        end else if (cnt_inc_c == CW'(LOCK_CNT)) begin
          state_nx = ST_LOCKED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc_c;
        end
      end else begin
        if (in_t_c) begin
          cnt_nx = '0;
        end else if (cnt_inc_c == CW'(LOSS_CNT)) begin
          state_nx = ST_SEARCH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc_c;
        end
      end
    end
  end

  // Monitor state register with registered lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEARCH;
      cnt       <= '0;
      converged <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      converged <= (state_nx == ST_LOCKED);
    end
  end

  // Window accumulator: publish the sum on the last transfer of each window
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      win_cnt      <= '0;
      energy       <= '0;
      energy_valid <= 1'b0;
    end else begin
      energy_valid <= 1'b0;
      if (xfer) begin
        if (win_cnt == WW'(WIN - 1)) begin
          energy       <= acc_sum_c;
          energy_valid <= 1'b1;
          acc          <= '0;
          win_cnt      <= '0;
        end else begin
          acc     <= acc_sum_c;
          win_cnt <= win_cnt + WW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/oe_pipe.sv
// Two-stage output-error pipeline: resolve carry-save Y, form E = D - Y.
module oe_pipe
  import oe_pkg::*;
#(
  parameter int unsigned DW       = 10,
  parameter int unsigned WIN      = 16,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW:0]                  sum,
  input  logic [DW:0]                  carry,
  input  logic [DW-1:0]                d,
  input  logic                         rnd_en,
  input  logic                         sat_en,
  input  logic [DW-2:0]                thresh,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                y,
  output logic [DW-1:0]                e,
  output logic                         e_sat,
  output logic                         converged,
  output logic [energy_w(DW, WIN)-1:0] energy,
  output logic                         energy_valid
);

  localparam logic [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

  logic          en_c;
  logic          xfer_c;
  logic [DW:0]   t_c;
  logic [DW-1:0] yt_c;
  logic [DW-1:0] y1_c;
  logic          s1_valid;
  logic [DW-1:0] s1_y;
  logic [DW-1:0] s1_d;
  logic          s1_sat;
  logic [DW:0]   x_c;
  logic          ovf_c;
  logic [DW-1:0] e2_c;
  logic          esat2_c;

  // Global advance: both stages move together whenever the output slot frees
  assign en_c     = !out_valid | out_ready;
  assign in_ready = en_c;
  assign xfer_c   = out_valid & out_ready;

  // Stage 1: resolve carry-save pair, optional round-half-up clamped at +max
  assign t_c  = sum + carry;
  assign yt_c = t_c[DW:1];
  assign y1_c = ((rnd_en == MODE_ROUND) && t_c[0] && (yt_c != Y_MAX)) ? yt_c + DW'(1) : yt_c;

  // Stage 2: exact difference in DW+1 bits, then clip or wrap
  assign x_c   = {s1_d[DW-1], s1_d} - {s1_y[DW-1], s1_y};
  assign ovf_c = x_c[DW] ^ x_c[DW-1];

  // Error saturation select
  always_comb begin
    e2_c    = x_c[DW-1:0];
    esat2_c = 1'b0;
    if ((s1_sat == MODE_SAT) && ovf_c) begin
      e2_c    = x_c[DW] ? Y_MIN : Y_MAX;
      esat2_c = 1'b1;
    end
  end

  // Pipeline registers; bubbles advance but leave payload untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_y      <= '0;
      s1_d      <= '0;
      s1_sat    <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      e         <= '0;
      e_sat     <= 1'b0;
    end else if (en_c) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_y   <= y1_c;
        s1_d   <= d;
        s1_sat <= sat_en;
      end
      if (s1_valid) begin
        y     <= s1_y;
        e     <= e2_c;
        e_sat <= esat2_c;
      end
    end
  end

  oe_conv_mon #(
    .DW       (DW),
    .WIN      (WIN),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT)
  ) u_mon (
    .clk          (clk),
    .rst          (rst),
    .xfer         (xfer_c),
    .e            (e),
    .thresh       (thresh),
    .converged    (converged),
    .energy       (energy),
    .energy_valid (energy_valid)
  );

endmodule

// File: tb/tb_oe_pipe.sv
// Self-checking bench for oe_pipe against a sample-level reference model.
module tb_oe_pipe;

  localparam int unsigned DW   = 10;
  localparam int unsigned WIN  = 4;
  localparam int unsigned LOCK = 8;
  localparam int unsigned LOSS = 4;
  localparam int unsigned EW   = 2 * DW + $clog2(WIN);
  localparam int          HALF = 1 << (DW - 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW:0]   sum;
  logic [DW:0]   carry;
  logic [DW-1:0] d;
  logic          rnd_en;
  logic          sat_en;
  logic [DW-2:0] thresh;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] y;
  logic [DW-1:0] e;
  logic          e_sat;
  logic          converged;
  logic [EW-1:0] energy;
  logic          energy_valid;

  oe_pipe #(.DW(DW), .WIN(WIN), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry(carry), .d(d), .rnd_en(rnd_en), .sat_en(sat_en),
    .thresh(thresh), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .e(e), .e_sat(e_sat), .converged(converged),
    .energy(energy), .energy_valid(energy_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: two pipeline slots carrying final expected results
  bit            mv1, mv2;
  logic [DW-1:0] my1, my2, me1, me2;
  bit            ms1, ms2;
  // Model: monitor and window statistics
  bit            m_locked;
  int            m_run;
  int            m_acc;
  int            m_wc;
  int            m_energy;
  bit            m_ev;
  int            ev_seen;
  int            xfer_n;
  bit            last_acc;
  logic [DW-1:0] oy, oe;
  logic          oes;

  function automatic logic [DW-1:0] w(input int v);
    return DW'(v);
  endfunction

  function automatic int sx(input logic [DW-1:0] v);
    return v[DW-1] ? int'(v) - (1 << DW) : int'(v);
  endfunction

  function automatic logic [DW-1:0] ref_y(input int s, input int c, input bit r);
    int t;
    int yy;
    t  = (s + c) % (1 << (DW + 1));
    yy = t / 2;
    if (yy >= HALF) yy -= 2 * HALF;
    if (r && (t % 2) == 1 && yy < HALF - 1) yy++;
    return w(yy);
  endfunction

  function automatic logic [DW:0] ref_e(input int dd, input int yy, input bit s);
    int x;
    bit c;
    x = dd - yy;
    c = 1'b0;
    if (s) begin
      if (x > HALF - 1) begin x = HALF - 1; c = 1'b1; end
      else if (x < -HALF) begin x = -HALF; c = 1'b1; end
    end
    return {c, w(x)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_xfer(input logic [DW-1:0] ev);
    int a;
    bit in_t;
    a = sx(ev);
    if (a < 0) a = -a;
    in_t = (a <= int'(thresh));
    if (!m_locked) begin
      m_run = in_t ? m_run + 1 : 0;
      if (m_run == LOCK) begin m_locked = 1'b1; m_run = 0; end
    end else begin
      m_run = in_t ? 0 : m_run + 1;
      if (m_run == LOSS) begin m_locked = 1'b0; m_run = 0; end
    end
    m_acc += a * a;
    m_wc++;
    if (m_wc == WIN) begin
      m_energy = m_acc;
      m_ev     = 1'b1;
      m_acc    = 0;
      m_wc     = 0;
    end
  endtask

  // One clock: predict, advance model on the edge, check just after it
  task automatic step();
    bit            xf, en;
    logic [DW-1:0] ny;
    logic [DW:0]   nr;
    logic [EW-1:0] men;
    xf = mv2 && out_ready;
    en = !mv2 || out_ready;
    last_acc = en && in_valid && !rst;
    ny = ref_y(int'(sum), int'(carry), rnd_en);
    nr = ref_e(sx(d), sx(ny), sat_en);
    @(posedge clk);
    m_ev = 1'b0;
    if (rst) begin
      mv1 = 0; mv2 = 0; m_locked = 0; m_run = 0;
      m_acc = 0; m_wc = 0; m_energy = 0;
    end else begin
      if (xf) begin model_xfer(me2); xfer_n++; end
      if (en) begin
        mv2 = mv1; my2 = my1; me2 = me1; ms2 = ms1;
        mv1 = in_valid;
        if (in_valid) begin my1 = ny; me1 = nr[DW-1:0]; ms1 = nr[DW]; end
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(mv2));
    chk("in_ready", 32'(in_ready), 32'(!mv2 || out_ready));
    if (mv2) begin
      chk("y", 32'(y), 32'(my2));
      chk("e", 32'(e), 32'(me2));
      chk("e_sat", 32'(e_sat), 32'(ms2));
    end
    men = EW'(m_energy);
    chk("converged", 32'(converged), 32'(m_locked));
    chk("energy_valid", 32'(energy_valid), 32'(m_ev));
    chk("energy", 32'(energy), 32'(men));
    if (energy_valid) ev_seen++;
  endtask

  task automatic set_in(input int s, input int c, input int dd, input bit r, input bit sa);
    in_valid = 1'b1;
    sum      = (DW + 1)'(s);
    carry    = (DW + 1)'(c);
    d        = w(dd);
    rnd_en   = r;
    sat_en   = sa;
  endtask

  // Send one sample alone, capture its output, then let it transfer
  task automatic send_drain(input int s, input int c, input int dd, input bit r, input bit sa);
    set_in(s, c, dd, r, sa);
    step();
    in_valid = 1'b0;
    step();
    oy = y; oe = e; oes = e_sat;
    step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  int s_arr [5];
  int k;
  int x0;
  int dd;

  initial begin
    rst = 1'b1; in_valid = 1'b0; sum = '0; carry = '0; d = '0;
    rnd_en = 1'b0; sat_en = 1'b0; thresh = '0; out_ready = 1'b1;
    mv1 = 0; mv2 = 0; my1 = '0; my2 = '0; me1 = '0; me2 = '0; ms1 = 0; ms2 = 0;
    m_locked = 0; m_run = 0; m_acc = 0; m_wc = 0; m_energy = 0; m_ev = 0;
    ev_seen = 0; xfer_n = 0; last_acc = 0;

    // Reset state
    do_reset(3);
    chk("rst_y", 32'(y), 32'(0));
    chk("rst_e", 32'(e), 32'(0));
    chk("rst_e_sat", 32'(e_sat), 32'(0));
    chk("rst_energy", 32'(energy), 32'(0));

    // Directed datapath cases
    send_drain(200, 101, 160, 1'b0, 1'b0);
    chk("trunc_y", 32'(oy), 32'(w(150)));
    chk("trunc_e", 32'(oe), 32'(w(10)));
    send_drain(200, 101, 160, 1'b1, 1'b0);
    chk("round_y", 32'(oy), 32'(w(151)));
    chk("round_e", 32'(oe), 32'(w(9)));
    send_drain(1000, 23, 0, 1'b1, 1'b0);
    chk("round_clip_y", 32'(oy), 32'(w(511)));
    send_drain(600, 0, -512, 1'b0, 1'b1);
    chk("sat_y", 32'(oy), 32'(w(300)));
    chk("sat_e", 32'(oe), 32'(w(-512)));
    chk("sat_flag", 32'(oes), 32'(1));
    send_drain(600, 0, -512, 1'b0, 1'b0);
    chk("wrap_e", 32'(oe), 32'(w(212)));
    chk("wrap_flag", 32'(oes), 32'(0));

    // Backpressure: five samples, output stalled for three cycles mid-stream
    for (int i = 0; i < 5; i++) s_arr[i] = int'($urandom_range(0, 2047));
    x0 = xfer_n;
    k = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      if (k < 5) set_in(s_arr[k], k * 7, k * 30 - 50, 1'b0, 1'b1);
      else in_valid = 1'b0;
      step();
      if (last_acc) k++;
      if (cyc >= 3 && cyc < 6) chk("stall_in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    chk("bp_accepted", 32'(k), 32'(5));
    chk("bp_transfers", 32'(xfer_n - x0), 32'(5));

    // Convergence monitor with hysteresis
    do_reset(1);
    thresh = (DW - 1)'(4);
    for (int i = 0; i < 8; i++) begin
      send_drain(0, 0, int'($urandom_range(0, 8)) - 4, 1'b0, 1'b0);
      if (i == 6) chk("mon_before_lock", 32'(converged), 32'(0));
    end
    chk("mon_locked", 32'(converged), 32'(1));
    for (int i = 0; i < 3; i++) begin
      dd = int'($urandom_range(5, 200));
      send_drain(0, 0, ($urandom_range(0, 1) != 0) ? dd : -dd, 1'b0, 1'b0);
    end
    send_drain(0, 0, -3, 1'b0, 1'b0);
    chk("mon_hold", 32'(converged), 32'(1));
    for (int i = 0; i < 4; i++) begin
      send_drain(0, 0, (i == 2) ? -512 : 5 + i, 1'b0, 1'b0);
      if (i == 2) chk("mon_hold_3", 32'(converged), 32'(1));
    end
    chk("mon_lost", 32'(converged), 32'(0));

    // Energy window of four back-to-back errors
    do_reset(1);
    ev_seen = 0;
    set_in(0, 0, 3, 1'b0, 1'b0);  step();
    set_in(0, 0, -4, 1'b0, 1'b0); step();
    set_in(0, 0, 0, 1'b0, 1'b0);  step();
    set_in(0, 0, 5, 1'b0, 1'b0);  step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("energy_pulses", 32'(ev_seen), 32'(1));
    chk("energy_50", 32'(energy), 32'(50));

    // Reset mid-window restarts accumulation from zero
    send_drain(0, 0, 7, 1'b0, 1'b0);
    send_drain(0, 0, 7, 1'b0, 1'b0);
    do_reset(1);
    ev_seen = 0;
    for (int i = 0; i < 4; i++) send_drain(0, 0, (i % 2 == 0) ? 1 : -1, 1'b0, 1'b0);
    chk("energy_after_rst", 32'(energy), 32'(4));
    chk("energy_rst_pulses", 32'(ev_seen), 32'(1));

    // Randomized traffic with backpressure, mode changes and occasional reset
    do_reset(1);
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 50 == 0) thresh = (DW - 1)'($urandom_range(0, 40));
      rst       = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      sum       = (DW + 1)'($urandom);
      carry     = (DW + 1)'($urandom);
      rnd_en    = $urandom_range(0, 1) != 0;
      sat_en    = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 1) != 0)
        d = w(sx(ref_y(int'(sum), int'(carry), rnd_en)) + int'($urandom_range(0, 12)) - 6);
      else
        d = DW'($urandom);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
